// File: rtl/exu_pkg.sv
// Shared definitions for the multi-cycle execute unit: op codes, FSM states,
// and the three-way compare encoding.
package exu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_SLT   = 4'd2,
        OP_SLTU  = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_CMPS  = 4'd10,
        OP_CMPU  = 4'd11,
        OP_MUL   = 4'd12,
        OP_MULHU = 4'd13
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] CMP_EQ = 3'd0;
    localparam logic [2:0] CMP_GT = 3'd2;
    localparam logic [2:0] CMP_LT = 3'd4;

    function automatic logic [2:0] cmp3(input logic eq, input logic gt);
        if (eq)      cmp3 = CMP_EQ;
        else if (gt) cmp3 = CMP_GT;
        else         cmp3 = CMP_LT;
    endfunction

endpackage

// File: rtl/exu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per step, XLEN steps.
// Only built when EXU_MUL_EN is defined.
`ifdef EXU_MUL_EN
module exu_mul_iter
    import exu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_sel,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [SHW:0] LAST = (SHW+1)'(XLEN - 1);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [SHW:0]      cnt_q, cnt_d;
    logic              hi_q, hi_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            hi_d     = hi_sel;
        end else if (step) begin
            acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // The final step's sum is forwarded so the result lands in the same edge.
    assign done   = step && (cnt_q == LAST);
    assign result = hi_q ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        hi_q     <= hi_d;
    end

endmodule
`endif

// File: rtl/exu_mc.sv
// Multi-cycle handshaked execute unit. Define EXU_MUL_EN to build the
// iterative MUL/MULHU path; otherwise those ops return 0 in one cycle.
module exu_mc
    import exu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic            src2_sel,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);

    function automatic logic [XLEN-1:0] alu(input op_e f, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [SHW-1:0]         sh;
        sa  = a;
        sb  = b;
        sh  = b[SHW-1:0];
        alu = '0;
        case (f)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_SLT:  alu = {{(XLEN-1){1'b0}}, (sa < sb)};
            OP_SLTU: alu = {{(XLEN-1){1'b0}}, (a < b)};
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            OP_SLL:  alu = a << sh;
            OP_SRL:  alu = a >> sh;
            OP_SRA:  alu = $unsigned(sa >>> sh);
            OP_CMPS: alu = {{(XLEN-3){1'b0}}, cmp3(sa == sb, sa > sb)};
            OP_CMPU: alu = {{(XLEN-3){1'b0}}, cmp3(a == b, a > b)};
            default: alu = '0;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic [XLEN-1:0] op_b;
    logic            accept;

    assign op_b      = src2_sel ? imm : rs2_data;
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef EXU_MUL_EN
    logic            is_mul;
    logic            mul_start;
    logic            mul_step;
    logic            mul_done;
    logic [XLEN-1:0] mul_res;

    assign is_mul    = (op_e'(op) == OP_MUL) || (op_e'(op) == OP_MULHU);
    assign mul_start = accept && is_mul;
    assign mul_step  = (state_q == ST_MUL) && !flush;
    assign busy      = (state_q == ST_MUL);

    exu_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .step   (mul_step),
        .a      (rs1_data),
        .b      (op_b),
        .hi_sel (op_e'(op) == OP_MULHU),
        .done   (mul_done),
        .result (mul_res)
    );
`else
    logic            is_mul;
    logic            mul_done;
    logic [XLEN-1:0] mul_res;

    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign busy     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_MUL: begin
                    if (mul_done) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = mul_res;
                    end
                end
                default: begin
                    // Drain first; a same-cycle accept below overrides the return to IDLE.
                    if ((state_q == ST_DONE) && out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                    if (accept) begin
                        if (is_mul) begin
                            state_d     = ST_MUL;
                            out_valid_d = 1'b0;
                        end else begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                            out_data_d  = alu(op_e'(op), rs1_data, op_b);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: doc/exu_mc.md
Name: exu_mc

Overview:
- Multi-cycle, handshaked execute unit for the NPC core; successor to the single-cycle combinational EXU.
- Takes decoded operands plus an op code and returns one registered result over valid/ready.
- Single-cycle ALU ops complete in 1 cycle; MUL/MULHU run on an iterative shift-add multiplier.
- Sits between IDU and LSU/WBU.

Parameters:
- XLEN, 32, datapath width; must be a power of 2, minimum 8.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- op  in  4  operation code (see package).
- src2_sel  in  1  0: use rs2_data; 1: use imm.
- rs1_data  in  XLEN  operand A.
- rs2_data  in  XLEN  operand B when src2_sel=0.
- imm  in  XLEN  operand B when src2_sel=1.
- flush  in  1  abort in-flight op and drop held result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  XLEN  result.
- busy  out  1  high in MUL state.

Behaviour:
- Reset: state=IDLE; out_valid=0; out_data=0; busy=0. in_ready=1 in the cycle after reset deasserts.
- Operand B: B = src2_sel ? imm : rs2_data.
- States: IDLE, MUL, DONE.
- Accept rule: a request is accepted when in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready).
- Single-cycle op accepted: out_data is registered; state goes to DONE; out_valid=1 the next cycle (latency 1).
- MUL/MULHU accepted: A and B are latched; state goes to MUL; counter=0; 2*XLEN accumulator=0.
  - Each MUL cycle: if multiplier bit 0 is set, add the shifted multiplicand; then shift; counter++.
  - After exactly XLEN cycles: MUL gives low XLEN bits, MULHU gives high XLEN bits; go to DONE.
  - Total latency XLEN+1 cycles from accept to out_valid.
- DONE: out_valid and out_data hold stable until out_ready.
  - out_ready && !accepting new: go to IDLE.
  - out_ready && new accept in the same cycle: proceed directly per the new op, giving back-to-back throughput of 1 op/cycle for single-cycle ops.
- Arithmetic (all results mod 2^XLEN):
  - ADD/SUB wrap.
  - SLT/SLTU give 1 or 0.
  - Shifts use B[SHW-1:0] only; SRA is sign-filling.
  - CMPS/CMPU give a three-way result: 0 if A==B, 2 if A>B, 4 if A<B (signed or unsigned respectively).
  - Undefined op codes give 0 with normal single-cycle latency.
- Input stability: inputs are ignored outside accept cycles.
- flush: highest priority after rst.
  - Next state is IDLE; out_valid=0; out_data keeps its value.
  - A request presented in the same cycle is NOT accepted.
- rst mid-MUL: behaves as reset; no result is emitted.
- Counter width is SHW+1 so it can represent XLEN.

Optional Feature:
- Macro EXU_MUL_EN.
- Defined: MUL/MULHU behave as above.
- Undefined: the MUL state and accumulator are not built; MUL/MULHU take the single-cycle path and return 0; busy is tied 0.

Decomposition:
- Package exu_pkg holds:
  - op code constants: ADD=0, SUB=1, SLT=2, SLTU=3, AND=4, OR=5, XOR=6, SLL=7, SRL=8, SRA=9, CMPS=10, CMPU=11, MUL=12, MULHU=13.
  - state encoding: IDLE=0, MUL=1, DONE=2.
  - three-way compare result constants.
- One sub-module, exu_mul_iter: iterative shift-add multiplier with start/done, instantiated only under EXU_MUL_EN.

Test Plan:
1. ADD rs1=0xFFFFFFFF, rs2=1, src2_sel=0, out_ready=1 -> out_valid one cycle later, out_data=0x00000000.
2. Back-to-back: SUB 5-7, then SRA 0x80000000 by imm=4, in_valid held, out_ready=1 -> 0xFFFFFFFE then 0xF8000000 on consecutive cycles; in_ready stays 1.
3. CMPS A=0xFFFFFFFF, B=1 -> 4. CMPU with the same operands -> 2. Equal operands -> 0.
4. MULHU 0xFFFFFFFF*0xFFFFFFFF (XLEN=32) -> busy for 32 cycles, out_valid at cycle 33, out_data=0xFFFFFFFE. MUL with the same operands -> 0x00000001.
5. Backpressure: result held with out_ready=0 for 5 cycles -> out_data stable, in_ready=0; then out_ready=1 -> handshake completes, state=IDLE.
6. flush at cycle 10 of a MUL -> next cycle out_valid=0, busy=0, in_ready=1. rst asserted mid-MUL -> same outcome, out_data=0.
